// File: rtl/control_sequencer.sv
// Multicycle control FSM: fetches an opcode over a handshake, decodes it and steps
// through execution states whose codes drive ALUControl directly on ALUOp.
module control_sequencer #(
    parameter int OPC_W   = 5,
    parameter int ALUOP_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic               fetch_req,
    input  logic               fetch_ack,
    input  logic [OPC_W-1:0]   opcode,
    output logic               mem_req,
    output logic               mem_we,
    input  logic               mem_ack,
    input  logic               alu_done,
    input  logic               cond_met,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               ir_write,
    output logic               pc_inc,
    output logic               pc_write,
    output logic               reg_write,
    output logic               flag_write,
    output logic               instr_done,
    output logic               illegal_op
);

    // Execution states reuse their ALUOp code as the state encoding.
    localparam logic [5:0] S_LW_1   = 6'd0;
    localparam logic [5:0] S_LW_2   = 6'd1;
    localparam logic [5:0] S_LW_3   = 6'd2;
    localparam logic [5:0] S_SW_1   = 6'd3;
    localparam logic [5:0] S_SW_2   = 6'd4;
    localparam logic [5:0] S_MOV    = 6'd5;
    localparam logic [5:0] S_ADD    = 6'd6;
    localparam logic [5:0] S_SUB    = 6'd7;
    localparam logic [5:0] S_MUL    = 6'd8;
    localparam logic [5:0] S_DIV    = 6'd9;
    localparam logic [5:0] S_AND    = 6'd10;
    localparam logic [5:0] S_OR     = 6'd11;
    localparam logic [5:0] S_SHL    = 6'd12;
    localparam logic [5:0] S_SHR    = 6'd13;
    localparam logic [5:0] S_CMP    = 6'd14;
    localparam logic [5:0] S_NOT    = 6'd15;
    localparam logic [5:0] S_JR     = 6'd16;
    localparam logic [5:0] S_JPC    = 6'd17;
    localparam logic [5:0] S_BRFL   = 6'd18;
    localparam logic [5:0] S_CALL   = 6'd19;
    localparam logic [5:0] S_RET    = 6'd20;
    localparam logic [5:0] S_NOP    = 6'd21;
    localparam logic [5:0] S_FETCH  = 6'd32;
    localparam logic [5:0] S_DECODE = 6'd33;

    logic [5:0]       state;
    logic [5:0]       next_state;
    logic [5:0]       exec_state;
    logic [OPC_W-1:0] ir;
    logic             fetch_live;
    logic             fetch_fire;

    // fetch_live keeps fetch_req low while reset is asserted and until the first clock after it.
    assign fetch_req  = fetch_live & run & (state == S_FETCH);
    assign fetch_fire = fetch_req & fetch_ack;
    assign ALUOp      = ALUOP_W'((state == S_FETCH || state == S_DECODE) ? S_NOP : state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            ir         <= '0;
            fetch_live <= 1'b0;
        end else begin
            state      <= next_state;
            fetch_live <= 1'b1;
            if (fetch_fire) begin
                ir <= opcode;
            end
        end
    end

    // Opcodes 2..18 map to consecutive execution states starting at MOV.
    always_comb begin
        exec_state = S_NOP;
        if (ir == OPC_W'(0)) begin
            exec_state = S_LW_1;
        end else if (ir == OPC_W'(1)) begin
            exec_state = S_SW_1;
        end else if (ir <= OPC_W'(18)) begin
            exec_state = 6'(ir) + 6'd3;
        end
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_inc     = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        flag_write = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                ir_write = fetch_fire;
                pc_inc   = fetch_fire;
                if (fetch_fire) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                illegal_op = (ir > OPC_W'(18));
                next_state = exec_state;
            end
            S_LW_1: next_state = S_LW_2;
            S_LW_2: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    next_state = S_LW_3;
                end
            end
            S_LW_3: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_SW_1: next_state = S_SW_2;
            S_SW_2: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                instr_done = mem_ack;
                if (mem_ack) begin
                    next_state = S_FETCH;
                end
            end
            S_MOV, S_ADD, S_SUB, S_AND, S_OR, S_SHL, S_SHR, S_NOT: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_MUL, S_DIV: begin
                reg_write  = alu_done;
                instr_done = alu_done;
                if (alu_done) begin
                    next_state = S_FETCH;
                end
            end
            S_CMP: begin
                flag_write = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_JR, S_RET: begin
                pc_write   = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_JPC, S_BRFL: begin
                pc_write   = cond_met;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_CALL: begin
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            S_NOP: begin
                instr_done = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
    end

endmodule
